arb_conv_8_32: RTL and testbench
================================

ARB_CONV_8_32 -- requirements
Module: arb_conv_8_32

Interface
REQ-001 Parameter: N_REQ, default 4, number of byte-stream requesters; legal values 2 and 4.
REQ-002 Parameter: ID_W, default 2, width of src_id; SHALL equal log2(N_REQ).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset_L  input  1  asynchronous active-low reset.
REQ-005 valid_in  input  N_REQ  per-requester byte-valid.
REQ-006 data_in  input  8*N_REQ  byte of requester k on bits [8k+7:8k].
REQ-007 req_mask  input  N_REQ  1 = requester enabled for arbitration.
REQ-008 ready_out  output  N_REQ  byte of requester k consumed on this edge (combinational).
REQ-009 data_out  output  32  packed word, first byte in [31:24], last byte in [7:0] (registered).
REQ-010 valid_out  output  1  one-cycle pulse, data_out/src_id valid (registered).
REQ-011 src_id  output  ID_W  requester that produced data_out (registered).
REQ-012 err_abort  output  1  one-cycle pulse, word aborted (registered).

Function
REQ-013 States: IDLE, PACK; byte counter cnt (2 bits); round-robin pointer last_gnt (ID_W bits).
REQ-014 Eligible(k) = valid_in[k] & req_mask[k].
REQ-015 In IDLE, winner = first eligible requester scanning last_gnt+1, last_gnt+2, ... modulo N_REQ; no eligible -> no winner, ready_out all 0.
REQ-016 In IDLE, ready_out SHALL be one-hot on the winner; on the edge the winner's byte is stored as byte 0, grant register <= winner, cnt <= 1, state <= PACK.
REQ-017 In PACK, ready_out[grant] = valid_in[grant]; all other ready_out bits 0, regardless of req_mask.
REQ-018 In PACK with valid_in[grant]=1: byte stored at lane cnt, cnt increments.
REQ-019 On the edge storing byte 3: data_out <= assembled word, src_id <= grant, valid_out <= 1, last_gnt <= grant, state <= IDLE, cnt <= 0.
REQ-020 Latency: valid_out high in the cycle immediately after the edge that accepts byte 3; exactly one cycle.
REQ-021 Back-to-back: the IDLE cycle following word completion SHALL arbitrate and accept a byte; sustained throughput one byte per cycle with no bubble.
REQ-022 Abort: in PACK, valid_in[grant]=0 at an edge -> partial word discarded, err_abort <= 1 for one cycle, last_gnt <= grant, state <= IDLE, cnt <= 0; data_out/src_id keep prior values, valid_out 0.
REQ-023 req_mask changes during PACK SHALL NOT affect the current grant; they apply at the next IDLE arbitration.
REQ-024 Non-granted requesters are never consumed; they hold valid_in/data_in until ready_out.
REQ-025 valid_out and err_abort SHALL never be high in the same cycle.
REQ-026 cnt wraps only via REQ-019/REQ-022; no other path returns to IDLE.

Reset
REQ-027 reset_L=0 asynchronously forces: state IDLE, cnt 0, last_gnt N_REQ-1 (requester 0 highest priority first), data_out 32'h0, valid_out 0, src_id 0, err_abort 0.
REQ-028 Reset mid-word discards partial data; no valid_out or err_abort pulse is generated for it.
REQ-029 ready_out SHALL be all 0 while reset_L=0.

Structure
REQ-030 Shared package conv_pkg holds state encodings (IDLE, PACK), byte-lane constants (4 bytes/word), and the N_REQ default.
REQ-031 One sub-module rr_pick: combinational round-robin selector (eligible vector, last_gnt -> winner index, found flag).
REQ-032 The byte-lane packing register lives in arb_conv_8_32; no separate converter instance.

Verification
REQ-033 Single requester 0, bytes 11,22,33,44 on consecutive cycles -> data_out 32'h11223344, src_id 0, valid_out one cycle after 4th byte.
REQ-034 Requesters 0 and 2 both continuously valid, mask 4'hF -> words alternate src_id 0,2,0,2; no bubble; 8 bytes in 8 cycles.
REQ-035 Requester 1 granted, drops valid after 2 bytes -> err_abort one pulse, no valid_out, next grant goes to requester 2 if eligible.
REQ-036 req_mask=4'b0101 with all valid -> only src_id 0 and 2 ever appear; clearing bit 0 mid-word still completes that word with src_id 0.
REQ-037 reset_L asserted after 3 bytes -> all outputs 0 immediately; after release, fresh 4 bytes from requester 0 produce a correct word with no stale byte.
REQ-038 Requester 3 valid with gaps of 1 idle cycle every byte -> counted as abort per REQ-022; bench checks err_abort count equals number of gaps in PACK.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the byte-to-word arbitrating converter.
package conv_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int N_REQ_DEFAULT  = 4;

   // Lane index of the final byte of a word; storing it completes the word.
   localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PACK = 1'b1
   } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: returns the first eligible requester
// after last_gnt, wrapping modulo N_REQ (N_REQ is a power of two).
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] eligible,
   input  logic [ID_W-1:0]  last_gnt,
   output logic [ID_W-1:0]  winner,
   output logic             found
);

   // Scan from farthest to nearest so the nearest eligible requester wins.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int i = N_REQ; i >= 1; i--) begin
         if (eligible[ID_W'(int'(last_gnt) + i)]) begin
            winner = ID_W'(int'(last_gnt) + i);
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arb_conv_8_32.sv
// Round-robin arbiter that packs four consecutive bytes from one requester
// into a 32-bit word (first byte in [31:24]).
//
// Handshake: a requester's byte is consumed on a rising edge exactly when
// ready_out[k] is high in the cycle before it; a requester holds valid_in and
// data_in until then. valid_out and err_abort are single-cycle pulses and are
// never high together. A granted requester that drops valid_in mid-word
// aborts the word.
module arb_conv_8_32
   import conv_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEFAULT,
   parameter int ID_W  = 2
) (
   input  logic                 clk,
   input  logic                 reset_L,
   input  logic [N_REQ-1:0]     valid_in,
   input  logic [8*N_REQ-1:0]   data_in,
   input  logic [N_REQ-1:0]     req_mask,
   output logic [N_REQ-1:0]     ready_out,
   output logic [31:0]          data_out,
   output logic                 valid_out,
   output logic [ID_W-1:0]      src_id,
   output logic                 err_abort,
   output logic                 dbg_state
);

   state_t          state_q, state_d;
   logic [1:0]      cnt_q, cnt_d;
   logic [ID_W-1:0] last_gnt_q, last_gnt_d;
   logic [ID_W-1:0] grant_q, grant_d;
   // Bytes 0..2 of the word in progress: byte 0 in [23:16], byte 2 in [7:0].
   logic [23:0]     pack_q, pack_d;
   logic [31:0]     data_out_d;
   logic [ID_W-1:0] src_id_d;
   logic            valid_out_d;
   logic            err_abort_d;

   logic [N_REQ-1:0] eligible;
   logic [ID_W-1:0]  winner;
   logic             found;
   logic [ID_W-1:0]  cur_idx;
   logic [7:0]       cur_byte;

   assign eligible  = valid_in & req_mask;
   assign cur_idx   = (state_q == ST_IDLE) ? winner : grant_q;
   assign cur_byte  = data_in[8*cur_idx +: 8];
   assign dbg_state = state_q;

   rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_rr_pick (
      .eligible (eligible),
      .last_gnt (last_gnt_q),
      .winner   (winner),
      .found    (found)
   );

   // Next-state, byte capture and ready generation for the IDLE/PACK FSM.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_gnt_d  = last_gnt_q;
      grant_d     = grant_q;
      pack_d      = pack_q;
      data_out_d  = data_out;
      src_id_d    = src_id;
      valid_out_d = 1'b0;
      err_abort_d = 1'b0;
      ready_out   = '0;

      case (state_q)
         ST_IDLE: begin
            if (found) begin
               ready_out[winner] = 1'b1;
               pack_d[23:16]     = cur_byte;
               grant_d           = winner;
               cnt_d             = 2'd1;
               state_d           = ST_PACK;
            end
         end
         ST_PACK: begin
            if (valid_in[grant_q]) begin
               ready_out[grant_q] = 1'b1;
               if (cnt_q == LAST_LANE) begin
                  data_out_d  = {pack_q, cur_byte};
                  src_id_d    = grant_q;
                  valid_out_d = 1'b1;
                  last_gnt_d  = grant_q;
                  cnt_d       = 2'd0;
                  state_d     = ST_IDLE;
               end else begin
                  case (cnt_q)
                     2'd1:    pack_d[15:8] = cur_byte;
                     default: pack_d[7:0]  = cur_byte;
                  endcase
                  cnt_d = cnt_q + 2'd1;
               end
            end else begin
               // Granted requester went quiet mid-word: drop the partial word.
               err_abort_d = 1'b1;
               last_gnt_d  = grant_q;
               cnt_d       = 2'd0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Nothing may be consumed while the block is held in reset.
      if (!reset_L) ready_out = '0;
   end

   // State and output registers; reset makes requester 0 highest priority.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 2'd0;
         last_gnt_q <= ID_W'(N_REQ - 1);
         grant_q    <= '0;
         pack_q     <= '0;
         data_out   <= 32'h0;
         src_id     <= '0;
         valid_out  <= 1'b0;
         err_abort  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_gnt_q <= last_gnt_d;
         grant_q    <= grant_d;
         pack_q     <= pack_d;
         data_out   <= data_out_d;
         src_id     <= src_id_d;
         valid_out  <= valid_out_d;
         err_abort  <= err_abort_d;
      end
   end

endmodule

// File: tb/tb_arb_conv_8_32.sv
// Self-checking bench for arb_conv_8_32: table-driven single-requester words,
// a word scoreboard fed by the stimulus, and hand-written corner sequences.
module tb_arb_conv_8_32;

   localparam int N_REQ = 4;
   localparam int ID_W  = 2;

   logic        clk = 1'b0;
   logic        reset_L;
   logic [3:0]  valid_in;
   logic [31:0] data_in;
   logic [3:0]  req_mask;
   logic [3:0]  ready_out;
   logic [31:0] data_out;
   logic        valid_out;
   logic [1:0]  src_id;
   logic        err_abort;
   logic        dbg_state;

   int total     = 0;
   int bad       = 0;
   int abort_cnt = 0;
   logic [33:0] exp_q[$];

   typedef struct {
      int          req;
      logic [3:0]  mask;
      logic [31:0] word;
   } vec_t;
   vec_t tbl[6];

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   arb_conv_8_32 #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
      .clk       (clk),
      .reset_L   (reset_L),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .req_mask  (req_mask),
      .ready_out (ready_out),
      .data_out  (data_out),
      .valid_out (valid_out),
      .src_id    (src_id),
      .err_abort (err_abort),
      .dbg_state (dbg_state)
   );

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      valid_in = '0;
      req_mask = 4'hF;
      data_in  = '0;
      reset_L  = 1'b0;
      step();
      step();
      reset_L  = 1'b1;
   endtask

   // Requester k alone sends word w; checks grant, latency and pulse width.
   task automatic send_word(input int k, input logic [3:0] m, input logic [31:0] w);
      logic [3:0] one_hot;
      one_hot  = 4'b0001 << k;
      req_mask = m;
      exp_q.push_back({2'(k), w});
      for (int b = 0; b < 4; b++) begin
         valid_in = one_hot;
         data_in  = '0;
         data_in[8*k +: 8] = w[8*(3-b) +: 8];
         #1;
         check("word_ready", 64'(ready_out), 64'(one_hot));
         step();
      end
      valid_in = '0;
      check("word_valid", 64'(valid_out), 64'd1);
      check("word_data", 64'(data_out), 64'(w));
      check("word_src", 64'(src_id), 64'(k));
      check("word_state", 64'(dbg_state), 64'd0);
      step();
      check("word_pulse", 64'(valid_out), 64'd0);
      req_mask = 4'hF;
   endtask

   // Continuous stream; exp_r nibble c is the expected ready_out in cycle c.
   task automatic stream(input int n, input logic [3:0] v, input logic [3:0] m0,
                         input int chg, input logic [3:0] m1, input logic [63:0] exp_r);
      int a_i;
      int c_i;
      logic [3:0] r;
      a_i = 0;
      c_i = 0;
      for (int c = 0; c < n; c++) begin
         req_mask = (c >= chg) ? m1 : m0;
         valid_in = v;
         data_in  = {8'hEE, 8'(8'hC0 + c_i), 8'hEE, 8'(8'h10 + a_i)};
         r = exp_r[4*c +: 4];
         #1;
         check("stream_ready", 64'(ready_out), 64'(r));
         if (r[0]) a_i++;
         if (r[2]) c_i++;
         step();
      end
      valid_in = '0;
      req_mask = 4'hF;
      step();
      step();
      check("stream_drained", 64'(exp_q.size()), 64'd0);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (reset_L === 1'b1) begin
         if (valid_out === 1'b1 || err_abort === 1'b1)
            check("pulse_exclusive", 64'(valid_out & err_abort), 64'd0);
         if (valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word", {30'd0, src_id, data_out}, 64'h0);
            end else begin
               logic [33:0] e;
               e = exp_q.pop_front();
               check("sb_word", {30'd0, src_id, data_out}, 64'(e));
            end
         end
         if (err_abort === 1'b1) abort_cnt++;
      end
   end

   // ---------------- test sequence ----------------
   initial begin
      int base;
      int gaps;
      int nb;

      // Reset state, with every requester presenting data.
      reset_L  = 1'b0;
      valid_in = 4'hF;
      req_mask = 4'hF;
      data_in  = 32'h12345678;
      #3;
      check("rst_ready", 64'(ready_out), 64'h0);
      check("rst_data", 64'(data_out), 64'h0);
      check("rst_valid", 64'(valid_out), 64'h0);
      check("rst_src", 64'(src_id), 64'h0);
      check("rst_abort", 64'(err_abort), 64'h0);
      check("rst_state", 64'(dbg_state), 64'h0);
      reset_dut();

      // Table-driven single-requester words.
      tbl[0] = '{req: 0, mask: 4'hF,    word: 32'h11223344};
      tbl[1] = '{req: 1, mask: 4'hF,    word: 32'hA5A55A5A};
      tbl[2] = '{req: 2, mask: 4'b0100, word: 32'hDEADBEEF};
      tbl[3] = '{req: 3, mask: 4'b1000, word: 32'h00FF00FF};
      tbl[4] = '{req: 1, mask: 4'b0011, word: 32'($urandom)};
      tbl[5] = '{req: 3, mask: 4'hF,    word: 32'hFFFFFFFF};
      for (int i = 0; i < 6; i++) begin
         send_word(tbl[i].req, tbl[i].mask, tbl[i].word);
         step();
      end

      // A masked-off requester is never granted.
      valid_in = 4'b0010;
      req_mask = 4'b1101;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("masked_ready", 64'(ready_out), 64'h0);
         step();
      end
      check("masked_state", 64'(dbg_state), 64'h0);
      valid_in = '0;
      req_mask = 4'hF;

      // Requesters 0 and 2 streaming: words alternate 0,2,0,2 with no bubble.
      reset_dut();
      exp_q.push_back({2'd0, 32'h10111213});
      exp_q.push_back({2'd2, 32'hC0C1C2C3});
      exp_q.push_back({2'd0, 32'h14151617});
      exp_q.push_back({2'd2, 32'hC4C5C6C7});
      stream(16, 4'b0101, 4'hF, 16, 4'hF, 64'h4444_1111_4444_1111);

      // Mask 0101 with all valid; clearing bit 0 mid-word keeps that word.
      reset_dut();
      exp_q.push_back({2'd0, 32'h10111213});
      exp_q.push_back({2'd2, 32'hC0C1C2C3});
      exp_q.push_back({2'd2, 32'hC4C5C6C7});
      stream(12, 4'hF, 4'b0101, 2, 4'b0100, 64'h0000_4444_4444_1111);

      // Requester 1 drops valid after two bytes; requester 2 is next.
      reset_dut();
      base = abort_cnt;
      valid_in = 4'b0010;
      data_in  = 32'h0000_A100;
      #1;
      check("ab_ready0", 64'(ready_out), 64'b0010);
      step();
      data_in  = 32'h0000_A200;
      #1;
      check("ab_ready1", 64'(ready_out), 64'b0010);
      step();
      valid_in = 4'b0101;
      data_in  = 32'h00D0_0077;
      #1;
      check("ab_ready_drop", 64'(ready_out), 64'h0);
      step();
      check("ab_pulse", 64'(err_abort), 64'd1);
      check("ab_no_valid", 64'(valid_out), 64'd0);
      check("ab_data_kept", 64'(data_out), 64'h0);
      check("ab_state", 64'(dbg_state), 64'd0);
      exp_q.push_back({2'd2, 32'hD0D1D2D3});
      for (int b = 0; b < 4; b++) begin
         data_in = {8'h00, 8'(8'hD0 + b), 8'h00, 8'h77};
         #1;
         check("ab_next_ready", 64'(ready_out), 64'b0100);
         step();
         if (b == 0) check("ab_one_pulse", 64'(err_abort), 64'd0);
      end
      valid_in = '0;
      check("ab_next_src", 64'(src_id), 64'd2);
      step();
      check("ab_count", 64'(abort_cnt - base), 64'd1);

      // Reset in the middle of a word clears everything immediately.
      reset_dut();
      base = abort_cnt;
      send_word(2, 4'hF, 32'h5A5A1234);
      req_mask = 4'hF;
      valid_in = 4'b0001;
      for (int b = 0; b < 3; b++) begin
         data_in = {24'h0, 8'(8'h55 + 8'h11 * b)};
         step();
      end
      #1;
      reset_L = 1'b0;
      #1;
      check("mid_rst_data", 64'(data_out), 64'h0);
      check("mid_rst_src", 64'(src_id), 64'h0);
      check("mid_rst_valid", 64'(valid_out), 64'h0);
      check("mid_rst_ready", 64'(ready_out), 64'h0);
      check("mid_rst_state", 64'(dbg_state), 64'h0);
      valid_in = '0;
      step();
      reset_L = 1'b1;
      send_word(0, 4'hF, 32'h99AABBCC);
      check("mid_rst_no_abort", 64'(abort_cnt - base), 64'd0);

      // Requester 3 with idle gaps: every gap inside a word is an abort.
      reset_dut();
      base = abort_cnt;
      gaps = 0;
      for (int g = 0; g < 5; g++) begin
         nb = $urandom_range(1, 3);
         for (int b = 0; b < nb; b++) begin
            valid_in = 4'b1000;
            data_in  = {8'($urandom), 24'h0};
            #1;
            check("gap_ready", 64'(ready_out), 64'b1000);
            step();
         end
         valid_in = '0;
         #1;
         check("gap_idle_ready", 64'(ready_out), 64'h0);
         step();
         gaps++;
         check("gap_abort", 64'(err_abort), 64'd1);
      end
      step();
      check("gap_count", 64'(abort_cnt - base), 64'(gaps));

      check("final_queue", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
